// File: rtl/debounce_sync.sv
// Switch debouncer: SYNC_STAGES-flop synchronizer feeding a 4-state stability FSM.
// Define DEBOUNCE_PULSE_EN to build the registered rise/fall edge pulses; otherwise they read 0.
module debounce_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int STABLE_CNT  = 10,
   parameter int CNT_W       = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic d_in,
   output logic q,
   output logic rise,
   output logic fall,
   output logic busy
);

   typedef enum logic [1:0] {
      LOW_STABLE,
      LOW_PENDING,
      HIGH_STABLE,
      HIGH_PENDING
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CNT - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   state_t                 state_q;
   logic [CNT_W-1:0]       count_q;
   logic                   q_q;
   logic                   differ;
   logic                   is_stable;
   logic                   toggle;

   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or posedge reset) begin
               if (reset) sync_q[gi] <= 1'b0;
               else       sync_q[gi] <= d_in;
            end
         end else begin : g_rest
            always_ff @(posedge clk or posedge reset) begin
               if (reset) sync_q[gi] <= 1'b0;
               else       sync_q[gi] <= sync_q[gi-1];
            end
         end
      end
   endgenerate

   assign sync_out  = sync_q[SYNC_STAGES-1];
   assign differ    = (sync_out != q_q);
   assign is_stable = (state_q == LOW_STABLE) || (state_q == HIGH_STABLE);
   // q flips on the edge whose increment would reach STABLE_CNT; with STABLE_CNT=1 that is the first disagreement
   assign toggle    = differ && (is_stable ? (STABLE_CNT == 1) : (count_q == LAST_CNT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= LOW_STABLE;
         count_q <= '0;
         q_q     <= 1'b0;
      end else if (toggle) begin
         state_q <= q_q ? LOW_STABLE : HIGH_STABLE;
         count_q <= '0;
         q_q     <= ~q_q;
      end else begin
         case (state_q)
            LOW_STABLE, HIGH_STABLE: begin
               if (differ) begin
                  state_q <= q_q ? HIGH_PENDING : LOW_PENDING;
                  count_q <= CNT_W'(1);
               end
            end
            LOW_PENDING, HIGH_PENDING: begin
               if (differ) begin
                  count_q <= count_q + CNT_W'(1);
               end else begin
                  state_q <= q_q ? HIGH_STABLE : LOW_STABLE;
                  count_q <= '0;
               end
            end
            default: begin
               state_q <= LOW_STABLE;
               count_q <= '0;
            end
         endcase
      end
   end

   assign q    = q_q;
   assign busy = (count_q != '0);

`ifdef DEBOUNCE_PULSE_EN
   logic rise_q;
   logic fall_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= toggle && !q_q;
         fall_q <= toggle && q_q;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed table-driven bench for debounce_sync at default parameters (clk period 4).
module tb_debounce_sync;

   logic clk = 1'b0;
   logic reset;
   logic d_in;
   logic q, rise, fall, busy;

   int checks = 0;
   int errors = 0;

`ifdef DEBOUNCE_PULSE_EN
   localparam bit PULSE_EN = 1'b1;
`else
   localparam bit PULSE_EN = 1'b0;
`endif

   typedef struct {
      logic d;
      logic exp_q;
      logic exp_rise;
      logic exp_fall;
      logic exp_busy;
   } vec_t;

   vec_t vecs[70];

   debounce_sync dut (
      .clk  (clk),
      .reset(reset),
      .d_in (d_in),
      .q    (q),
      .rise (rise),
      .fall (fall),
      .busy (busy)
   );

   always #2 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic eq, input logic er,
                            input logic ef, input logic eb);
      check({tag, ".q"}, q, eq);
      check({tag, ".rise"}, rise, er);
      check({tag, ".fall"}, fall, ef);
      check({tag, ".busy"}, busy, eb);
      $display("%s d_in=%b q=%b rise=%b fall=%b busy=%b", tag, d_in, q, rise, fall, busy);
   endtask

   initial begin
      // Segment A (0..19): clean 0->1 step; q flips after edge 12, busy after edges 3..11
      for (int k = 1; k <= 20; k++) begin
         vecs[k-1].d        = 1'b1;
         vecs[k-1].exp_q    = (k >= 12);
         vecs[k-1].exp_rise = (k == 12) && PULSE_EN;
         vecs[k-1].exp_fall = 1'b0;
         vecs[k-1].exp_busy = (k >= 3) && (k <= 11);
      end
      // Segment B (20..49): 9 low, 1 high glitch, 20 low from q=1; fall after edge 22
      for (int k = 1; k <= 30; k++) begin
         vecs[19+k].d        = (k == 10);
         vecs[19+k].exp_q    = (k < 22);
         vecs[19+k].exp_rise = 1'b0;
         vecs[19+k].exp_fall = (k == 22) && PULSE_EN;
         vecs[19+k].exp_busy = ((k >= 3) && (k <= 11)) || ((k >= 13) && (k <= 21));
      end
      // Segment C (50..69): 5-cycle high pulse from q=0 is rejected
      for (int k = 1; k <= 20; k++) begin
         vecs[49+k].d        = (k <= 5);
         vecs[49+k].exp_q    = 1'b0;
         vecs[49+k].exp_rise = 1'b0;
         vecs[49+k].exp_fall = 1'b0;
         vecs[49+k].exp_busy = (k >= 3) && (k <= 7);
      end

      reset = 1'b1;
      d_in  = 1'b0;
      #1;
      check_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         check_all($sformatf("reset_hold%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check_all($sformatf("post_reset%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
      end

      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         d_in = vecs[i].d;
         @(posedge clk); #1;
         check_all($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_rise,
                   vecs[i].exp_fall, vecs[i].exp_busy);
      end

      // Mid-count reset: count is 6 after edge 8 of a new high level
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         d_in = 1'b1;
         @(posedge clk); #1;
         check_all($sformatf("pre_abort%0d", k), 1'b0, 1'b0, 1'b0, (k >= 3));
      end
      #1;
      reset = 1'b1;
      #1;
      check_all("abort_async", 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         check_all($sformatf("abort_hold%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Release with d_in held high: treated as a fresh change, q rises after 12 edges
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk); #1;
         check_all($sformatf("held_high%0d", k), (k >= 12), (k == 12) && PULSE_EN,
                   1'b0, (k >= 3) && (k <= 11));
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
